// File: rtl/ps2_cmd_framer.sv
// ps2_cmd_framer: frames a PS/2 command byte, pulses send, retries on NACK/timeout
module ps2_cmd_framer #(
  parameter int SEND_HOLD      = 4,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 22
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic [7:0]  cmd_byte,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [0:10] frame,
  output logic        send,
  input  logic        tx_ok,
  input  logic        tx_err,
  output logic        done,
  output logic        fail,
  output logic        busy,
  output logic [1:0]  tries
);
  typedef enum logic [2:0] {IDLE, PULSE, WAIT, RETRY, GAP, DONE, FAIL} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0] tries_n;
  logic [0:10] frame_n;
  logic tx_ok_q, ok_rise;
  assign ok_rise = tx_ok & ~tx_ok_q;
  assign send = state == PULSE;
  assign done = state == DONE;
  assign fail = state == FAIL;
  assign cmd_ready = state == IDLE;
  assign busy = state == PULSE || state == WAIT || state == RETRY || state == GAP;
  // state, shared hold/timeout counter, attempt count, latched frame and ok history
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      tries <= '0;
      frame <= '0;
      tx_ok_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tries <= tries_n;
      frame <= frame_n;
      tx_ok_q <= tx_ok;
    end
  end
  // next state; the counter restarts on every state change so each state times itself
  always_comb begin
    state_n = state;
    tries_n = tries;
    frame_n = frame;
    case (state)
      IDLE: if (cmd_valid) begin
        state_n = PULSE;
        frame_n = {1'b1, ~^cmd_byte, cmd_byte, 1'b0};
        tries_n = '0;
      end
      PULSE: state_n = cnt == CNT_W'(SEND_HOLD - 1) ? WAIT : PULSE;
      WAIT: state_n = ok_rise ? (tx_err ? RETRY : DONE) :
                      cnt == CNT_W'(TIMEOUT_CYCLES - 1) ? RETRY : WAIT;
      RETRY: begin
        state_n = tries == 2'(MAX_RETRY) ? FAIL : GAP;
        tries_n = tries == 2'(MAX_RETRY) ? tries : tries + 2'd1;
      end
      GAP: state_n = cnt == CNT_W'(SEND_HOLD - 1) ? PULSE : GAP;
      default: state_n = IDLE;
    endcase
    cnt_n = (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
  end
endmodule

// File: tb/tb_ps2_cmd_framer.sv
// tb_ps2_cmd_framer: scoreboard bench for the PS/2 command framer
module tb_ps2_cmd_framer;
  localparam int SH = 4;
  localparam int TO = 100;
  logic qzt_clk = 0, reset = 1, cmd_valid = 0, tx_ok = 0, tx_err = 0;
  logic [7:0] cmd_byte = 0;
  logic cmd_ready, send, done, fail, busy;
  logic [0:10] frame;
  logic [1:0] tries;
  int checks = 0, errors = 0;
  typedef struct {logic f; logic [1:0] t; logic [0:10] fr;} exp_t;
  exp_t sb[$];
  exp_t e;
  int hi_len = 0, lo_len = 0, pulses = 0;
  logic acc = 0, send_q = 0;

  always #5 qzt_clk = ~qzt_clk;

  ps2_cmd_framer #(.SEND_HOLD(SH), .TIMEOUT_CYCLES(TO), .MAX_RETRY(3), .CNT_W(22)) dut (
    .qzt_clk(qzt_clk), .reset(reset), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .frame(frame), .send(send), .tx_ok(tx_ok), .tx_err(tx_err),
    .done(done), .fail(fail), .busy(busy), .tries(tries));

  function automatic logic [0:10] mk(input logic [7:0] b);
    logic [0:10] f;
    f[10] = 1'b0;
    f[0] = 1'b1;
    f[1] = ~^b;
    for (int i = 0; i < 8; i++) f[9-i] = b[i];
    return f;
  endfunction

  // monitor: latency, pulse width, gap between pulses, and scoreboard pop on done/fail
  always @(negedge qzt_clk) begin
    if (reset) begin
      hi_len = 0; lo_len = 0; pulses = 0; acc = 0; send_q = 0;
    end else begin
      if (acc) begin
        checks++;
        if (send !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL latency: send=%b busy=%b ready=%b, want 1 1 0", send, busy, cmd_ready);
        end
      end
      acc = cmd_valid && cmd_ready;
      if (acc) begin pulses = 0; lo_len = 0; end
      if (!send && send_q) begin
        checks++;
        if (hi_len != SH) begin errors++; $display("FAIL send_width: got %0d want %0d", hi_len, SH); end
        lo_len = 0;
      end
      if (send && !send_q) begin
        if (pulses > 0) begin
          checks++;
          if (lo_len < SH) begin errors++; $display("FAIL send_gap: got %0d want >=%0d", lo_len, SH); end
        end
        pulses++;
        hi_len = 0;
      end
      if (send) hi_len++; else lo_len++;
      if (done || fail) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: done=%b fail=%b with empty scoreboard", done, fail);
        end else begin
          e = sb.pop_front();
          if (fail !== e.f || done !== !e.f || tries !== e.t || frame !== e.fr || busy !== 1'b0 || pulses != int'(e.t) + 1) begin
            errors++;
            $display("FAIL result: done=%b fail=%b tries=%0d frame=%b busy=%b pulses=%0d, want fail=%b tries=%0d frame=%b busy=0 pulses=%0d",
                     done, fail, tries, frame, busy, pulses, e.f, e.t, e.fr, int'(e.t) + 1);
          end
        end
      end
      send_q = send;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge qzt_clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] b, input logic f, input logic [1:0] t);
    int k = 0;
    while (!cmd_ready && k < 1000) begin cyc(1); k++; end
    checks++;
    if (!cmd_ready) begin errors++; $display("FAIL issue_ready: ready=%b want 1", cmd_ready); return; end
    cmd_byte = b;
    cmd_valid = 1;
    sb.push_back('{f, t, mk(b)});
    cyc(1);
    cmd_valid = 0;
  endtask

  task automatic wait_fall(output bit ok);
    int k = 0;
    ok = 0;
    while (send !== 1'b1 && k < 1000) begin @(negedge qzt_clk); k++; end
    while (send !== 1'b0 && k < 1000) begin @(negedge qzt_clk); k++; end
    ok = k < 1000;
    if (!ok) begin checks++; errors++; $display("FAIL send_timeout: send=%b want a full pulse", send); end
  endtask

  task automatic respond(input logic err, input int d);
    bit ok;
    wait_fall(ok);
    if (!ok) return;
    cyc(d);
    tx_ok = 1; tx_err = err;
    cyc(3);
    tx_ok = 0; tx_err = 0;
  endtask

  task automatic finish_cmd();
    int k = 0;
    while ((sb.size() != 0 || !cmd_ready) && k < 2000) begin cyc(1); k++; end
    checks++;
    if (sb.size() != 0 || !cmd_ready) begin
      errors++;
      $display("FAIL finish: pending=%0d ready=%b want 0 1", sb.size(), cmd_ready);
    end
  endtask

  task automatic test_reset();
    cyc(3);
    checks++;
    if (cmd_ready !== 1 || send !== 0 || done !== 0 || fail !== 0 || busy !== 0 || tries !== 0 || frame !== 11'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b send=%b done=%b fail=%b busy=%b tries=%0d frame=%b", cmd_ready, send, done, fail, busy, tries, frame);
    end
    reset = 0;
    cyc(2);
  endtask

  task automatic test_basic();
    issue(8'hF4, 0, 0);
    checks++;
    if (frame !== 11'b10111101000) begin errors++; $display("FAIL frame_f4: got %b want 10111101000", frame); end
    respond(0, 50);
    finish_cmd();
    checks++;
    if (busy !== 0 || tries !== 0 || cmd_ready !== 1) begin
      errors++; $display("FAIL basic_idle: busy=%b tries=%0d ready=%b want 0 0 1", busy, tries, cmd_ready);
    end
  endtask

  task automatic test_parity();
    logic [7:0] bs [3];
    logic ps [3];
    bs[0] = 8'hFF; bs[1] = 8'h00; bs[2] = 8'h01;
    ps[0] = 1'b1; ps[1] = 1'b1; ps[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(bs[i], 0, 0);
      checks++;
      if (frame[1] !== ps[i] || frame[0] !== 1'b1 || frame[10] !== 1'b0) begin
        errors++;
        $display("FAIL parity_%h: par=%b stop=%b start=%b want %b 1 0", bs[i], frame[1], frame[0], frame[10], ps[i]);
      end
      respond(0, 10);
      finish_cmd();
    end
  endtask

  task automatic test_nack();
    issue(8'hE8, 0, 2);
    respond(1, 30);
    respond(1, 30);
    respond(0, 30);
    finish_cmd();
    checks++;
    if (tries !== 2) begin errors++; $display("FAIL nack_tries: got %0d want 2", tries); end
  endtask

  task automatic test_timeout();
    issue(8'hF2, 1, 3);
    finish_cmd();
    checks++;
    if (tries !== 3 || cmd_ready !== 1) begin
      errors++; $display("FAIL timeout_end: tries=%0d ready=%b want 3 1", tries, cmd_ready);
    end
  endtask

  task automatic test_stale_ok();
    bit ok;
    tx_ok = 1;
    cyc(2);
    issue(8'hF6, 0, 0);
    wait_fall(ok);
    cyc(20);
    checks++;
    if (busy !== 1 || sb.size() != 1) begin
      errors++; $display("FAIL stale_ok: busy=%b pending=%0d want 1 1", busy, sb.size());
    end
    cmd_byte = 8'hAA;
    cmd_valid = 1;
    cyc(1);
    checks++;
    if (cmd_ready !== 0) begin errors++; $display("FAIL wait_ready: got %b want 0", cmd_ready); end
    cmd_valid = 0;
    tx_ok = 0;
    cyc(2);
    tx_ok = 1;
    finish_cmd();
    tx_ok = 0;
    cyc(20);
    checks++;
    if (busy !== 0 || cmd_ready !== 1 || sb.size() != 0) begin
      errors++; $display("FAIL not_queued: busy=%b ready=%b pending=%0d want 0 1 0", busy, cmd_ready, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    issue(8'h5A, 0, 0);
    wait_fall(ok);
    cyc(10);
    #2 reset = 1;
    #1;
    checks++;
    if (send !== 0 || busy !== 0 || done !== 0 || fail !== 0) begin
      errors++; $display("FAIL reset_mid: send=%b busy=%b done=%b fail=%b want 0 0 0 0", send, busy, done, fail);
    end
    sb.delete();
    cyc(2);
    reset = 0;
    checks++;
    if (cmd_ready !== 1 || tries !== 0 || frame !== 11'b0) begin
      errors++; $display("FAIL after_reset: ready=%b tries=%0d frame=%b want 1 0 0", cmd_ready, tries, frame);
    end
    cyc(1);
    issue(8'hF3, 0, 0);
    respond(0, 40);
    finish_cmd();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_nack();
    test_timeout();
    test_stale_ok();
    test_reset_mid();
    cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_cmd_framer.md
Name: ps2_cmd_framer

Overview:
- Command-side stage directly upstream of the PS/2 host transmitter (ps2 send stage).
- Accepts a command byte from the mouse controller via valid/ready.
- Builds the 11-bit PS/2 frame with start, odd parity and stop bits, then issues a rising edge on the transmitter's send input.
- Waits for the transmitter's ok/err result, retries on NACK or timeout, and reports done or fail upstream.

Parameters:
- SEND_HOLD, 4, cycles send is held high (must be >=2 so the transmitter sees a clean edge)
- TIMEOUT_CYCLES, 2500000, cycles to wait for ok before a try is declared lost (50 ms at 50 MHz)
- MAX_RETRY, 3, extra attempts after the first failed attempt
- CNT_W, 22, width of the timeout counter (must hold TIMEOUT_CYCLES)

Ports:
- qzt_clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_byte  in  8  command byte to send to the device
- cmd_valid  in  1  command present
- cmd_ready  out  1  framer idle and able to accept a command
- frame  out  [0:10]  frame to the transmitter's data input
- send  out  1  to the transmitter's send input (edge-triggered there)
- tx_ok  in  1  transmitter ok level
- tx_err  in  1  transmitter err level (ack bit was high)
- done  out  1  one-cycle pulse: command acknowledged
- fail  out  1  one-cycle pulse: retries exhausted
- busy  out  1  high from acceptance until done/fail
- tries  out  2  attempts used for the last/current command (0 = first try)

Behaviour:
Reset values:
- frame=11'b0; send=0; cmd_ready=1; done=0; fail=0; busy=0; tries=0; state=IDLE; counters cleared.

Frame layout (vector indexed [0:10]; the transmitter shifts out frame[10] first):
- frame[10]=0 (start)
- frame[9]=D0 … frame[2]=D7 (LSB first)
- frame[1]=~^cmd_byte (odd parity)
- frame[0]=1 (stop)
- frame is latched once at acceptance and held stable until the next acceptance.

Edge detection:
- tx_ok is registered once; ok_rise = tx_ok & ~tx_ok_q.

State machine:
- IDLE: cmd_ready=1. On cmd_valid, accept the byte (one-cycle handshake), latch frame, tries=0, busy=1, go to PULSE.
- PULSE: send=1 for exactly SEND_HOLD cycles, then send=0 and go to WAIT. The timeout counter is cleared on entry to PULSE.
- WAIT: timeout counter increments each cycle.
  - On ok_rise: if tx_err=0, go to DONE; if tx_err=1, go to RETRY.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ok_rise, go to RETRY.
  - ok_rise takes priority over timeout in the same cycle.
- RETRY: if tries==MAX_RETRY, go to FAIL. Otherwise tries=tries+1 and go to GAP.
- GAP: idle for SEND_HOLD cycles with send=0, so the transmitter sees send low before the next edge; then go to PULSE. The same frame is resent.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- FAIL: fail=1 for one cycle, busy=0, go to IDLE.

Boundary conditions and timing:
- A level-high tx_ok left over from a previous transfer does not count; only a rising edge observed in WAIT completes a try.
- Any ok_rise seen in PULSE or GAP is ignored.
- cmd_valid outside IDLE is ignored; cmd_ready stays 0 until the cycle after the done/fail pulse.
- Back-to-back commands: IDLE is occupied for at least 1 cycle between commands.
- Reset asserted mid-transfer: send drops to 0 immediately (asynchronous) and all state returns to its reset value. No done or fail pulse is generated.
- tries saturates at MAX_RETRY (2-bit counter; MAX_RETRY must be <=3).
- Latency from acceptance to the first send rise: 1 cycle.

Test Plan:
- Reset then cmd_byte=8'hF4, cmd_valid=1 for one cycle → frame[10..0]=0,0,0,1,0,1,1,1,1,0,1 (parity 0). send high for 4 cycles starting 1 cycle after acceptance. Model tx_ok rising 200 cycles later with tx_err=0 → one done pulse, tries=0, busy falls, cmd_ready=1.
- cmd_byte=8'hFF → frame[1]=1. cmd_byte=8'h00 → frame[1]=1. cmd_byte=8'h01 → frame[1]=0. frame[0]=1 and frame[10]=0 in every case.
- NACK: model returns ok with tx_err=1 twice, then tx_err=0 → three send pulses, each separated by send low for at least 4 cycles; done pulse with tries=2; no fail pulse.
- Timeout: no tx_ok response (TIMEOUT_CYCLES overridden to 100) → 4 send pulses roughly 100+ cycles apart, then one fail pulse with tries=3; cmd_ready returns to 1.
- Stale ok: tx_ok held high before the command is accepted and staying high through PULSE → no done. Model drops ok, then raises it in WAIT → done on the rise. cmd_valid pulsed during WAIT → ignored and not queued.
- Reset asserted during WAIT → send, busy, done and fail all 0 in the same cycle. After release, state is IDLE with cmd_ready=1; a new 8'hF3 command completes normally.
